dot_matrix_scan_ctrl: RTL and testbench

- Parametrised, double-buffered scan controller for N side-by-side LED dot-matrix panels that share one set of row lines.
- Game logic writes rows into a back buffer, then requests a swap; the swap takes effect only at a frame boundary, so no partial frames are ever displayed.
- Adds per-row PWM brightness and frame-counted blinking.
- Sits between the display-pattern logic and the board pins.

---
 rtl/dot_matrix_scan_ctrl_if.sv | 33 +++
 rtl/dot_matrix_scan_ctrl.sv | 144 ++++++++++++++
 tb/tb_dot_matrix_scan_ctrl.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_matrix_scan_ctrl_if.sv
// Bus between the display-pattern logic and the dot-matrix scan controller:
// back-buffer writes, swap request, brightness/blink controls and panel pins.
interface dot_matrix_scan_ctrl_if #(
  parameter int N_PANELS = 2,
  parameter int ROWS     = 8,
  parameter int COLS     = 8,
  parameter int PWM_BITS = 3
);
  localparam int PANEL_W = (N_PANELS > 1) ? $clog2(N_PANELS) : 1;
  localparam int ROW_W   = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic                     wr_en;
  logic [PANEL_W-1:0]       wr_panel;
  logic [ROW_W-1:0]         wr_row;
  logic [COLS-1:0]          wr_data;
  logic                     swap_req;
  logic                     swap_done;
  logic [PWM_BITS-1:0]      brightness;
  logic                     blink_en;
  logic                     frame_start;
  logic [ROWS-1:0]          row;
  logic [N_PANELS*COLS-1:0] col;

  modport master (
    output wr_en, wr_panel, wr_row, wr_data, swap_req, brightness, blink_en,
    input  swap_done, frame_start, row, col
  );

  modport slave (
    input  wr_en, wr_panel, wr_row, wr_data, swap_req, brightness, blink_en,
    output swap_done, frame_start, row, col
  );
endinterface

// File: rtl/dot_matrix_scan_ctrl.sv
// Double-buffered row-scan controller for side-by-side LED dot-matrix panels
// with frame-aligned buffer swap, per-row PWM brightness and frame-counted blink.
module dot_matrix_scan_ctrl #(
  parameter int N_PANELS     = 2,
  parameter int ROWS         = 8,
  parameter int COLS         = 8,
  parameter int SCAN_DIV     = 5000,
  parameter int PWM_BITS     = 3,
  parameter int BLINK_FRAMES = 25
) (
  input logic                   clk,
  input logic                   rst,
  dot_matrix_scan_ctrl_if.slave bus
);
  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int LIM_W = DIV_W + PWM_BITS + 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  logic [COLS-1:0]          fb_r [2][N_PANELS][ROWS];
  logic [DIV_W-1:0]         div_cnt_r;
  logic [ROW_W-1:0]         row_sel_r;
  logic                     active_r;
  logic                     swap_pending_r;
  logic                     blink_phase_r;
  logic [FRM_W-1:0]         frame_cnt_r;
  logic [LIM_W-1:0]         on_limit_r;
  logic [ROWS-1:0]          row_r;
  logic [N_PANELS*COLS-1:0] col_r;
  logic                     swap_done_r;
  logic                     frame_start_r;

  logic                     terminal_s;
  logic                     boundary_s;
  logic                     do_swap_s;
  logic                     wr_ok_s;
  logic                     lit_s;
  logic                     frame_start_s;
  logic [LIM_W-1:0]         on_limit_s;
  logic [ROWS-1:0]          row_s;
  logic [N_PANELS*COLS-1:0] col_s;

  // Scan position decode, swap decision, write qualification and next pin values
  always_comb begin
    terminal_s    = (div_cnt_r == DIV_LAST);
    boundary_s    = terminal_s && (row_sel_r == ROW_LAST);
    do_swap_s     = boundary_s && (swap_pending_r || bus.swap_req);
    wr_ok_s       = bus.wr_en && (32'(bus.wr_row) < 32'(ROWS))
                    && (32'(bus.wr_panel) < 32'(N_PANELS));
    on_limit_s    = ((LIM_W'(bus.brightness) + LIM_W'(1)) * LIM_W'(SCAN_DIV)) >> PWM_BITS;
    lit_s         = (LIM_W'(div_cnt_r) < on_limit_r) && !(bus.blink_en && blink_phase_r);
    frame_start_s = (div_cnt_r == DIV_W'(0)) && (row_sel_r == ROW_W'(0));
    row_s         = '1;
    col_s         = '0;
    for (int r = 0; r < ROWS; r++) begin
      row_s[r] = (row_sel_r != ROW_W'(r));
    end
    for (int p = 0; p < N_PANELS; p++) begin
      if (lit_s) begin
        col_s[p*COLS +: COLS] = fb_r[active_r][p][row_sel_r];
      end else begin
        col_s[p*COLS +: COLS] = '0;
      end
    end
  end

  // Row timing, frame-boundary swap, blink counter and PWM limit sampled at row start
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_r      <= '0;
      row_sel_r      <= '0;
      active_r       <= 1'b0;
      swap_pending_r <= 1'b0;
      blink_phase_r  <= 1'b0;
      frame_cnt_r    <= '0;
      on_limit_r     <= on_limit_s;
    end else begin
      if (terminal_s) begin
        div_cnt_r  <= '0;
        on_limit_r <= on_limit_s;
        if (row_sel_r == ROW_LAST) begin
          row_sel_r <= '0;
        end else begin
          row_sel_r <= row_sel_r + ROW_W'(1);
        end
      end else begin
        div_cnt_r <= div_cnt_r + DIV_W'(1);
      end
      if (do_swap_s) begin
        active_r       <= ~active_r;
        swap_pending_r <= 1'b0;
      end else if (bus.swap_req) begin
        swap_pending_r <= 1'b1;
      end
      if (boundary_s) begin
        if (frame_cnt_r == FRM_LAST) begin
          frame_cnt_r   <= '0;
          blink_phase_r <= ~blink_phase_r;
        end else begin
          frame_cnt_r <= frame_cnt_r + FRM_W'(1);
        end
      end
    end
  end

  // Back-buffer writes; the side not displayed this cycle takes the data
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int p = 0; p < N_PANELS; p++) begin
          for (int r = 0; r < ROWS; r++) begin
            fb_r[b][p][r] <= '0;
          end
        end
      end
    end else if (wr_ok_s) begin
      fb_r[~active_r][bus.wr_panel][bus.wr_row] <= bus.wr_data;
    end
  end

  // Registered pin drivers, one cycle behind the scan state
  always_ff @(posedge clk) begin
    if (rst) begin
      row_r         <= '1;
      col_r         <= '0;
      swap_done_r   <= 1'b0;
      frame_start_r <= 1'b0;
    end else begin
      row_r         <= row_s;
      col_r         <= col_s;
      swap_done_r   <= do_swap_s;
      frame_start_r <= frame_start_s;
    end
  end

  assign bus.row         = row_r;
  assign bus.col         = col_r;
  assign bus.swap_done   = swap_done_r;
  assign bus.frame_start = frame_start_r;
endmodule

// File: tb/tb_dot_matrix_scan_ctrl.sv
// Self-checking bench: cycle scoreboard for a 2x8x8 controller plus direct
// sequences, and a 3-panel/6-row instance for out-of-range write handling.
module tb_dot_matrix_scan_ctrl;
  localparam int NP = 2, NR = 8, NC = 8, DIV = 8, PB = 3, BF = 2;
  localparam int FRAME = DIV * NR;
  localparam int FRAME2 = DIV * 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dot_matrix_scan_ctrl_if #(.N_PANELS(NP), .ROWS(NR), .COLS(NC), .PWM_BITS(PB)) bus ();
  dot_matrix_scan_ctrl #(.N_PANELS(NP), .ROWS(NR), .COLS(NC), .SCAN_DIV(DIV),
                         .PWM_BITS(PB), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  dot_matrix_scan_ctrl_if #(.N_PANELS(3), .ROWS(6), .COLS(4), .PWM_BITS(PB)) bus2 ();
  dot_matrix_scan_ctrl #(.N_PANELS(3), .ROWS(6), .COLS(4), .SCAN_DIV(DIV),
                         .PWM_BITS(PB), .BLINK_FRAMES(BF)) dut2 (
    .clk(clk), .rst(rst), .bus(bus2)
  );

  typedef struct {
    logic [NR-1:0]    row;
    logic [NP*NC-1:0] col;
    logic             fs;
    logic             sd;
  } exp_t;

  typedef struct {
    logic [PB-1:0] bright;
    int            on_cnt;
  } bvec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;

  // reference state: two frame buffers, which one is shown, pending swap, time since reset
  logic [NC-1:0] m_buf [2][NP][NR];
  logic          m_act;
  logic          m_pend;
  int            t;
  int            m_lim;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  // one clock: predict the pins after this edge, queue it, then advance the reference
  task automatic tick();
    exp_t e;
    int rs, dv;
    rs = (t / DIV) % NR;
    dv = t % DIV;
    e.row = '1;
    e.col = '0;
    e.fs  = 1'b0;
    e.sd  = 1'b0;
    if (!rst) begin
      e.row[rs] = 1'b0;
      e.fs = ((t % FRAME) == 0);
      e.sd = ((t % FRAME) == FRAME - 1) && (m_pend || bus.swap_req);
      if (dv < m_lim && !(bus.blink_en && (((t / FRAME) / BF) % 2 == 1))) begin
        for (int p = 0; p < NP; p++) e.col[p*NC +: NC] = m_buf[m_act][p][rs];
      end
    end
    sb_q.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int p = 0; p < NP; p++)
          for (int r = 0; r < NR; r++) m_buf[b][p][r] = '0;
      m_act  = 1'b0;
      m_pend = 1'b0;
      t      = 0;
      m_lim  = ((int'(bus.brightness) + 1) * DIV) >> PB;
    end else begin
      if (bus.wr_en) m_buf[m_act ^ 1'b1][bus.wr_panel][bus.wr_row] = bus.wr_data;
      if (e.sd) begin
        m_act  = m_act ^ 1'b1;
        m_pend = 1'b0;
      end else if (bus.swap_req) begin
        m_pend = 1'b1;
      end
      if (dv == DIV - 1) m_lim = ((int'(bus.brightness) + 1) * DIV) >> PB;
      t++;
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // advance until the next cycle to be driven sits at the given frame offset
  task automatic run_to(input int ph);
    for (int i = 0; i < 2 * FRAME && (t % FRAME) != ph; i++) tick();
  endtask

  task automatic write(input int p, input int r, input logic [NC-1:0] d);
    bus.wr_en    = 1'b1;
    bus.wr_panel = p[0];
    bus.wr_row   = r[2:0];
    bus.wr_data  = d;
    tick();
    bus.wr_en    = 1'b0;
  endtask

  task automatic write2(input int p, input int r, input logic [3:0] d);
    bus2.wr_en    = 1'b1;
    bus2.wr_panel = p[1:0];
    bus2.wr_row   = r[2:0];
    bus2.wr_data  = d;
    tick();
    bus2.wr_en    = 1'b0;
  endtask

  // scoreboard monitor, sampling on the falling edge
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      chk("sb_row", 64'(bus.row), 64'(mon_e.row));
      chk("sb_col", 64'(bus.col), 64'(mon_e.col));
      chk("sb_frame_start", 64'(bus.frame_start), 64'(mon_e.fs));
      chk("sb_swap_done", 64'(bus.swap_done), 64'(mon_e.sd));
    end
  end

  initial begin
    bvec_t bv [4];
    int cnt, exp_on;
    logic [NP*NC-1:0] acc;
    logic [11:0] acc2;

    bv[0] = '{3'd7, 8};
    bv[1] = '{3'd3, 4};
    bv[2] = '{3'd0, 1};
    bv[3] = '{3'd5, 6};

    rst = 1'b1;
    bus.wr_en = 1'b0; bus.wr_panel = '0; bus.wr_row = '0; bus.wr_data = '0;
    bus.swap_req = 1'b0; bus.brightness = 3'd7; bus.blink_en = 1'b0;
    bus2.wr_en = 1'b0; bus2.wr_panel = '0; bus2.wr_row = '0; bus2.wr_data = '0;
    bus2.swap_req = 1'b0; bus2.brightness = 3'd7; bus2.blink_en = 1'b0;
    t = 0; m_act = 1'b0; m_pend = 1'b0; m_lim = DIV;

    // reset then two frames of plain scanning
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_row", 64'(bus.row), 64'hFF);
      chk("reset_col", 64'(bus.col), 64'h0);
    end
    rst = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 2 * FRAME; i++) begin
      tick();
      if (bus.frame_start) cnt++;
      if (i == 1)  chk("row_first", 64'(bus.row), 64'hFE);
      if (i == 9)  chk("row_second", 64'(bus.row), 64'hFD);
      if (i == 57) chk("row_last", 64'(bus.row), 64'h7F);
    end
    chk("frame_start_count", 64'(cnt), 64'd2);

    // swap requested mid-frame takes effect at the boundary
    run_to(10);
    write(0, 2, 8'hA5);
    write(1, 2, 8'h3C);
    bus.swap_req = 1'b1; tick(); bus.swap_req = 1'b0;
    acc = '0;
    for (int i = 0; i < 2 * FRAME && !bus.swap_done; i++) begin
      acc |= bus.col;
      tick();
    end
    chk("swap_done_seen", 64'(bus.swap_done), 64'd1);
    chk("pre_swap_col", 64'(acc), 64'h0);
    run_to(2 * DIV + 5);
    chk("row2_after_swap", 64'(bus.col), 64'h3CA5);

    // swap_req and write on the boundary cycle itself
    run_to(FRAME - 1);
    bus.swap_req = 1'b1;
    write(0, 0, 8'hFF);
    bus.swap_req = 1'b0;
    chk("same_cycle_swap", 64'(bus.swap_done), 64'd1);
    run_to(4);
    chk("same_cycle_write", 64'(bus.col), 64'h00FF);

    // two requests in one frame give a single swap
    run_to(8);
    bus.swap_req = 1'b1; tick(); bus.swap_req = 1'b0;
    run_to(30);
    bus.swap_req = 1'b1; tick(); bus.swap_req = 1'b0;
    cnt = 0;
    for (int i = 0; i < 80; i++) begin
      tick();
      if (bus.swap_done) cnt++;
    end
    chk("double_req_one_swap", 64'(cnt), 64'd1);

    // fill the back buffer, show it, then sweep brightness
    for (int p = 0; p < NP; p++)
      for (int r = 0; r < NR; r++) write(p, r, 8'hFF);
    bus.swap_req = 1'b1; tick(); bus.swap_req = 1'b0;
    for (int i = 0; i < 2 * FRAME && !bus.swap_done; i++) tick();
    chk("fill_swap_done", 64'(bus.swap_done), 64'd1);
    for (int k = 0; k < 4; k++) begin
      bus.brightness = bv[k].bright;
      run(2 * DIV);
      cnt = 0;
      for (int i = 0; i < DIV; i++) begin
        tick();
        if (bus.col != '0) cnt++;
      end
      chk("pwm_on_cycles", 64'(cnt), 64'(bv[k].on_cnt));
    end

    // blinking: two frames shown, two frames dark
    bus.brightness = 3'd7;
    bus.blink_en = 1'b1;
    run_to(0);
    for (int f = 0; f < 4; f++) begin
      exp_on = (((t / FRAME) / BF) % 2 == 0) ? FRAME : 0;
      cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
        tick();
        if (bus.col != '0) cnt++;
      end
      chk("blink_frame", 64'(cnt), 64'(exp_on));
    end
    bus.blink_en = 1'b0;
    for (int f = 0; f < 2; f++) begin
      cnt = 0;
      for (int i = 0; i < FRAME; i++) begin
        tick();
        if (bus.col != '0) cnt++;
      end
      chk("blink_off_frame", 64'(cnt), 64'(FRAME));
    end

    // reset mid-frame with a swap pending
    run_to(10);
    write(0, 5, 8'h81);
    bus.swap_req = 1'b1; tick(); bus.swap_req = 1'b0;
    run_to(30);
    rst = 1'b1;
    tick();
    chk("midreset_row", 64'(bus.row), 64'hFF);
    chk("midreset_col", 64'(bus.col), 64'h0);
    chk("midreset_swap_done", 64'(bus.swap_done), 64'd0);
    tick();
    rst = 1'b0;
    cnt = 0;
    acc = '0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      tick();
      if (bus.swap_done) cnt++;
      acc |= bus.col;
    end
    chk("after_reset_no_swap", 64'(cnt), 64'd0);
    chk("after_reset_blank", 64'(acc), 64'h0);

    // out-of-range writes on the 3-panel, 6-row instance are dropped
    write2(3, 0, 4'hF);
    write2(0, 6, 4'hF);
    write2(0, 7, 4'hF);
    write2(2, 7, 4'hF);
    write2(1, 1, 4'h9);
    write2(3, 6, 4'hF);
    bus2.swap_req = 1'b1; tick(); bus2.swap_req = 1'b0;
    run(2 * FRAME2);
    cnt = 0;
    acc2 = '0;
    for (int i = 0; i < FRAME2; i++) begin
      tick();
      if (bus2.col != '0) cnt++;
      acc2 |= bus2.col;
    end
    chk("oor_lit_cycles", 64'(cnt), 64'(DIV));
    chk("oor_pattern", 64'(acc2), 64'h090);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
